// File: rtl/etapa_id_ex.sv
`default_nettype none
// ============================================================================
//  Module   : etapa_id_ex
//  Brief    : ID/EX pipeline stage. Decodes RV32I R/I-type ALU instructions
//             into a 2-bit ALU op, resolves operands (EX/MEM and MEM/WB
//             forwarding, register/immediate select, shift-amount masking)
//             and registers them behind a valid/ready handshake with flush.
//  Revision : 1.0 - initial release
// ============================================================================
module etapa_id_ex #(
    parameter int ANCHO  = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic [4:0]       rd_addr,
    input  logic [ANCHO-1:0] rs1_data,
    input  logic [ANCHO-1:0] rs2_data,
    input  logic [ANCHO-1:0] imm,
    input  logic             exmem_we,
    input  logic             memwb_we,
    input  logic [4:0]       exmem_rd,
    input  logic [4:0]       memwb_rd,
    input  logic [ANCHO-1:0] exmem_res,
    input  logic [ANCHO-1:0] memwb_res,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO-1:0] Operando_A,
    output logic [ANCHO-1:0] Operando_B,
    output logic [1:0]       Control,
    output logic [4:0]       rd_out,
    output logic             we_out,
    output logic             illegal
);

    localparam logic [6:0] C_OP_R    = 7'b0110011;
    localparam logic [6:0] C_OP_I    = 7'b0010011;
    localparam logic [1:0] C_ALU_ADD = 2'b00;
    localparam logic [1:0] C_ALU_SRA = 2'b01;
    localparam logic [1:0] C_ALU_AND = 2'b10;
    localparam logic [1:0] C_ALU_XOR = 2'b11;

    logic             r_valid;
    logic [ANCHO-1:0] r_op_a;
    logic [ANCHO-1:0] r_op_b;
    logic [1:0]       r_ctrl;
    logic [4:0]       r_rd;
    logic             r_we;
    logic             r_illegal;

    logic             w_is_r;
    logic             w_is_i;
    logic             w_legal;
    logic [1:0]       w_ctrl;
    logic [ANCHO-1:0] w_src_a;
    logic [ANCHO-1:0] w_src_b;
    logic [ANCHO-1:0] w_op_b_raw;
    logic [ANCHO-1:0] w_op_b;
    logic             w_capture;

    // Decode opcode/funct into the ALU op; unsupported combinations stay ADD and flag illegal.
    always_comb begin
        w_is_r  = (opcode == C_OP_R);
        w_is_i  = (opcode == C_OP_I);
        w_legal = 1'b0;
        w_ctrl  = C_ALU_ADD;
        if (w_is_r || w_is_i) begin
            case (funct3)
                3'b000: if (w_is_i || !funct7_b5) begin w_legal = 1'b1; w_ctrl = C_ALU_ADD; end
                3'b101: if (funct7_b5)            begin w_legal = 1'b1; w_ctrl = C_ALU_SRA; end
                3'b111: if (w_is_i || !funct7_b5) begin w_legal = 1'b1; w_ctrl = C_ALU_AND; end
                3'b100: if (w_is_i || !funct7_b5) begin w_legal = 1'b1; w_ctrl = C_ALU_XOR; end
                default: ;
            endcase
        end
    end

    // Source operand resolution; x0 always reads as zero, EX/MEM beats MEM/WB.
    generate
        if (FWD_EN) begin : g_fwd
            assign w_src_a = (rs1_addr == 5'd0)                        ? '0        :
                             (exmem_we && (exmem_rd == rs1_addr))      ? exmem_res :
                             (memwb_we && (memwb_rd == rs1_addr))      ? memwb_res :
                                                                         rs1_data;
            assign w_src_b = (rs2_addr == 5'd0)                        ? '0        :
                             (exmem_we && (exmem_rd == rs2_addr))      ? exmem_res :
                             (memwb_we && (memwb_rd == rs2_addr))      ? memwb_res :
                                                                         rs2_data;
        end else begin : g_no_fwd
            assign w_src_a = (rs1_addr == 5'd0) ? '0 : rs1_data;
            assign w_src_b = (rs2_addr == 5'd0) ? '0 : rs2_data;
        end
    endgenerate

    // Shift amounts are clipped to 5 bits so the ALU never sees more than 31.
    assign w_op_b_raw = w_is_i ? imm : w_src_b;
    assign w_op_b     = (w_legal && (w_ctrl == C_ALU_SRA))
                        ? {{(ANCHO-5){1'b0}}, w_op_b_raw[4:0]}
                        : w_op_b_raw;

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    // Pipeline register: reset beats flush, flush beats capture, otherwise drain on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_ctrl    <= 2'b00;
            r_rd      <= 5'd0;
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_op_a    <= w_src_a;
            r_op_b    <= w_op_b;
            r_ctrl    <= w_ctrl;
            r_rd      <= rd_addr;
            r_we      <= w_legal && (rd_addr != 5'd0);
            r_illegal <= !w_legal;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign Operando_A = r_op_a;
    assign Operando_B = r_op_b;
    assign Control    = r_ctrl;
    assign rd_out     = r_rd;
    assign we_out     = r_we;
    assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_etapa_id_ex.sv
`default_nettype none
// ============================================================================
//  Module   : tb_etapa_id_ex
//  Brief    : Directed self-checking bench for the ID/EX stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_etapa_id_ex;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, funct7_b5;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, rd_out;
    logic [31:0] rs1_data, rs2_data, imm, exmem_res, memwb_res, Operando_A, Operando_B;
    logic        exmem_we, memwb_we, flush, out_valid, out_ready, we_out, illegal;
    logic [1:0]  Control;

    int checks = 0;
    int errors = 0;

    etapa_id_ex #(.ANCHO(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .exmem_we(exmem_we), .memwb_we(memwb_we), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_res(exmem_res), .memwb_res(memwb_res), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .Operando_A(Operando_A),
        .Operando_B(Operando_B), .Control(Control), .rd_out(rd_out),
        .we_out(we_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Drive one decoded instruction onto the input bus.
    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
        opcode = op; funct3 = f3; funct7_b5 = b5;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
        rs1_data = d1; rs2_data = d2; imm = im;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        exmem_we = 1'b0; memwb_we = 1'b0; exmem_rd = 5'd0; memwb_rd = 5'd0;
        exmem_res = 32'h0; memwb_res = 32'h0;
        set_instr(OP_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        tick(); tick();
        checks++; if (out_valid !== 1'b0)      begin errors++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
        checks++; if (Operando_A !== 32'h0)    begin errors++; $display("FAIL rst_a: got %h exp 0", Operando_A); end
        checks++; if (Operando_B !== 32'h0)    begin errors++; $display("FAIL rst_b: got %h exp 0", Operando_B); end
        checks++; if (Control !== 2'b00)       begin errors++; $display("FAIL rst_ctrl: got %b exp 00", Control); end
        checks++; if (rd_out !== 5'd0)         begin errors++; $display("FAIL rst_rd: got %0d exp 0", rd_out); end
        checks++; if (we_out !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rst_we_ill: got %b%b exp 00", we_out, illegal); end
        checks++; if (in_ready !== 1'b1)       begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1)      begin errors++; $display("FAIL rst_first_cap: got %b exp 1", out_valid); end
        checks++; if (Operando_A !== 32'd5)    begin errors++; $display("FAIL rst_first_a: got %h exp 5", Operando_A); end
    endtask

    task automatic test_add();
        set_instr(OP_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (Operando_A !== 32'd5)    begin errors++; $display("FAIL add_a: got %h exp 5", Operando_A); end
        checks++; if (Operando_B !== 32'd7)    begin errors++; $display("FAIL add_b: got %h exp 7", Operando_B); end
        checks++; if (Control !== 2'b00)       begin errors++; $display("FAIL add_ctrl: got %b exp 00", Control); end
        checks++; if (rd_out !== 5'd3)         begin errors++; $display("FAIL add_rd: got %0d exp 3", rd_out); end
        checks++; if (we_out !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL add_we_ill: got %b%b exp 10", we_out, illegal); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0)      begin errors++; $display("FAIL add_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_shift();
        in_valid = 1'b1; out_ready = 1'b1;
        set_instr(OP_I, 3'b101, 1'b1, 5'd1, 5'd0, 5'd4, 32'h8000_0000, 32'd0, 32'h0000_0423);
        tick();
        checks++; if (Control !== 2'b01)       begin errors++; $display("FAIL srai_ctrl: got %b exp 01", Control); end
        checks++; if (Operando_B !== 32'd3)    begin errors++; $display("FAIL srai_b: got %h exp 3", Operando_B); end
        checks++; if (Operando_A !== 32'h8000_0000) begin errors++; $display("FAIL srai_a: got %h exp 80000000", Operando_A); end
        checks++; if (we_out !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL srai_we_ill: got %b%b exp 10", we_out, illegal); end
        set_instr(OP_R, 3'b101, 1'b1, 5'd1, 5'd2, 5'd5, 32'h8000_0000, 32'hFFFF_FFE5, 32'h0000_0423);
        tick();
        checks++; if (Operando_B !== 32'd5)    begin errors++; $display("FAIL sra_b: got %h exp 5", Operando_B); end
        checks++; if (Control !== 2'b01)       begin errors++; $display("FAIL sra_ctrl: got %b exp 01", Control); end
        set_instr(OP_I, 3'b101, 1'b0, 5'd1, 5'd0, 5'd4, 32'h8000_0000, 32'd0, 32'h0000_0003);
        tick();
        checks++; if (illegal !== 1'b1 || we_out !== 1'b0) begin errors++; $display("FAIL srli_ill_we: got %b%b exp 10", illegal, we_out); end
        checks++; if (Control !== 2'b00)       begin errors++; $display("FAIL srli_ctrl: got %b exp 00", Control); end
    endtask

    task automatic test_forwarding();
        in_valid = 1'b1; out_ready = 1'b1;
        exmem_we = 1'b1; exmem_rd = 5'd6; exmem_res = 32'hAA;
        memwb_we = 1'b1; memwb_rd = 5'd6; memwb_res = 32'hBB;
        set_instr(OP_R, 3'b000, 1'b0, 5'd6, 5'd2, 5'd7, 32'h11, 32'd7, 32'd0);
        tick();
        checks++; if (Operando_A !== 32'hAA)   begin errors++; $display("FAIL fwd_exmem: got %h exp aa", Operando_A); end
        checks++; if (Operando_B !== 32'd7)    begin errors++; $display("FAIL fwd_b_none: got %h exp 7", Operando_B); end
        exmem_we = 1'b0;
        tick();
        checks++; if (Operando_A !== 32'hBB)   begin errors++; $display("FAIL fwd_memwb: got %h exp bb", Operando_A); end
        exmem_we = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        set_instr(OP_R, 3'b000, 1'b0, 5'd0, 5'd2, 5'd7, 32'h55, 32'd7, 32'd0);
        tick();
        checks++; if (Operando_A !== 32'h0)    begin errors++; $display("FAIL fwd_x0: got %h exp 0", Operando_A); end
        exmem_rd = 5'd2; exmem_res = 32'hCC; memwb_rd = 5'd2; memwb_res = 32'hDD;
        set_instr(OP_R, 3'b000, 1'b0, 5'd6, 5'd2, 5'd7, 32'h11, 32'd7, 32'd0);
        tick();
        checks++; if (Operando_B !== 32'hCC)   begin errors++; $display("FAIL fwd_rs2: got %h exp cc", Operando_B); end
        checks++; if (Operando_A !== 32'h11)   begin errors++; $display("FAIL fwd_rs1_none: got %h exp 11", Operando_A); end
        exmem_we = 1'b0; memwb_we = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall_flush();
        in_valid = 1'b1; out_ready = 1'b1;
        set_instr(OP_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0);
        tick();
        out_ready = 1'b0;
        set_instr(OP_R, 3'b100, 1'b0, 5'd8, 5'd9, 5'd5, 32'h10, 32'h20, 32'd0);
        exmem_we = 1'b1; exmem_rd = 5'd1; exmem_res = 32'h99;
        #1;
        checks++; if (in_ready !== 1'b0)       begin errors++; $display("FAIL stall_in_ready: got %b exp 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_vr%0d: got %b%b exp 10", i, out_valid, in_ready); end
            checks++; if (Operando_A !== 32'd1 || Operando_B !== 32'd2 || Control !== 2'b00 || rd_out !== 5'd3) begin
                errors++; $display("FAIL stall_hold%0d: got %h %h %b %0d exp 1 2 00 3", i, Operando_A, Operando_B, Control, rd_out); end
        end
        exmem_we = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)       begin errors++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
        tick();
        checks++; if (Operando_A !== 32'h10 || Operando_B !== 32'h20 || Control !== 2'b11 || rd_out !== 5'd5) begin
            errors++; $display("FAIL release_cap: got %h %h %b %0d exp 10 20 11 5", Operando_A, Operando_B, Control, rd_out); end
        out_ready = 1'b0;
        set_instr(OP_R, 3'b111, 1'b0, 5'd8, 5'd9, 5'd6, 32'h30, 32'h40, 32'd0);
        tick();
        checks++; if (Operando_A !== 32'h10 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_flush: got %h %b exp 10 1", Operando_A, out_valid); end
        flush = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || we_out !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b%b exp 00", out_valid, we_out); end
        tick();
        checks++; if (out_valid !== 1'b0 || Operando_A !== 32'h10) begin errors++; $display("FAIL flush_nocap: got %b %h exp 0 10", out_valid, Operando_A); end
        flush = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || Control !== 2'b10 || Operando_A !== 32'h30) begin
            errors++; $display("FAIL post_flush_cap: got %b %b %h exp 1 10 30", out_valid, Control, Operando_A); end
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; out_ready = 1'b1;
        set_instr(OP_R, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        tick();
        checks++; if (illegal !== 1'b1 || we_out !== 1'b0) begin errors++; $display("FAIL ill_r: got %b%b exp 10", illegal, we_out); end
        checks++; if (Control !== 2'b00 || out_valid !== 1'b1) begin errors++; $display("FAIL ill_r_ctrl: got %b %b exp 00 1", Control, out_valid); end
        checks++; if (Operando_A !== 32'd5 || Operando_B !== 32'd7) begin errors++; $display("FAIL ill_r_ops: got %h %h exp 5 7", Operando_A, Operando_B); end
        set_instr(7'b0000011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        tick();
        checks++; if (illegal !== 1'b1 || we_out !== 1'b0) begin errors++; $display("FAIL ill_op: got %b%b exp 10", illegal, we_out); end
        set_instr(OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, 32'h10);
        tick();
        checks++; if (illegal !== 1'b0 || we_out !== 1'b0) begin errors++; $display("FAIL addi_x0: got %b%b exp 00", illegal, we_out); end
        checks++; if (Operando_B !== 32'h10)   begin errors++; $display("FAIL addi_x0_b: got %h exp 10", Operando_B); end
        set_instr(OP_I, 3'b000, 1'b1, 5'd1, 5'd0, 5'd9, 32'd5, 32'd0, 32'hFFFF_FFFF);
        tick();
        checks++; if (illegal !== 1'b0 || we_out !== 1'b1 || Operando_B !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL addi_b5: got %b%b %h exp 01 ffffffff", illegal, we_out, Operando_B); end
        set_instr(OP_I, 3'b100, 1'b0, 5'd1, 5'd0, 5'd9, 32'd5, 32'd0, 32'h0000_0423);
        tick();
        checks++; if (Control !== 2'b11 || Operando_B !== 32'h0000_0423) begin
            errors++; $display("FAIL xori: got %b %h exp 11 00000423", Control, Operando_B); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_forwarding();
        test_stall_flush();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/etapa_id_ex.md
Name: etapa_id_ex

Overview:
ID/EX pipeline stage directly upstream of the execute ALU (ops 00 ADD, 01 arithmetic shift right, 10 AND, 11 XOR).
- Decodes RV32I R/I-type ALU instructions into the 2-bit ALU control code.
- Selects operand B as register or immediate, applies EX/MEM and MEM/WB forwarding, and registers the result.
- Its registered outputs drive Operando_A, Operando_B and Control of the ALU, with a valid/ready handshake plus flush.

Parameters:
ANCHO, 32, datapath width; only 32 is supported.
FWD_EN, 1, 1 = forwarding enabled; 0 = register-file data always used.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  decoded instruction present
in_ready  output  1  stage can accept this cycle
opcode  input  7  instruction[6:0]
funct3  input  3  instruction[14:12]
funct7_b5  input  1  instruction[30]
rs1_addr, rs2_addr, rd_addr  input  5 each  register indices
rs1_data, rs2_data  input  32 each  register-file read data
imm  input  32  sign-extended I-type immediate
exmem_we, memwb_we  input  1 each  later-stage write enables
exmem_rd, memwb_rd  input  5 each  later-stage destinations
exmem_res, memwb_res  input  32 each  later-stage results
flush  input  1  kill held/incoming instruction
out_valid  output  1  Operando_A/B, Control valid
out_ready  input  1  execute stage accepts
Operando_A, Operando_B  output  32 each  registered ALU operands
Control  output  2  registered ALU op code
rd_out  output  5  destination passed down
we_out  output  1  write enable passed down
illegal  output  1  instruction not supported by this stage

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-low on rst_n.
- Reset value: while rst_n=0 at a clk edge, all outputs are cleared to 0 (out_valid, Operando_A/B, Control, rd_out, we_out, illegal). in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Capture happens when in_valid & in_ready; latency is 1 cycle from capture to out_valid=1.
  - Hold: while out_valid & !out_ready, all outputs are stable.
  - Drain: out_valid falls when the output is accepted and no new capture occurs.
- Flush: at a clk edge with flush=1, out_valid<=0, we_out<=0, illegal<=0, and no capture that cycle, even if in_valid & in_ready. rst_n has priority over flush.
- Decode, R-type (opcode 0110011):
  - funct3 000, b5=0 -> Control 00
  - funct3 101, b5=1 -> Control 01
  - funct3 111, b5=0 -> Control 10
  - funct3 100, b5=0 -> Control 11
- Decode, I-type (opcode 0010011): same funct3 mapping. funct7_b5 must be 1 for SRAI and is ignored for the others.
- Illegal instructions: any other opcode/funct combination is still captured with illegal=1, we_out=0, Control=00 and operands as computed. Otherwise illegal=0.
- we_out = legal & (rd_addr != 0).
- Forwarding (per source, evaluated at capture):
  - If exmem_we & exmem_rd==rsX_addr & rsX_addr!=0, use exmem_res.
  - Else if memwb_we & memwb_rd==rsX_addr & rsX_addr!=0, use memwb_res.
  - Else use rsX_data.
  - EX/MEM has priority over MEM/WB. x0 reads as 0 regardless of rs1_data/rs2_data.
  - With FWD_EN=0, always use rsX_data (x0 still forced to 0).
- Operand A = forwarded rs1.
- Operand B = forwarded rs2 (R-type) or imm (I-type).
- Shifts (Control 01): Operando_B = {27'b0, B[4:0]}, so the ALU never sees a shift amount above 31.
- Operands are not re-sampled while held; forwarding changes during a stall do not alter outputs.

Test Plan:
- Reset with in_valid=1 -> all outputs 0; first edge with rst_n=1 captures; out_valid=1 one cycle later.
- ADD x3,x1,x2 with rs1_data=5, rs2_data=7, no forwarding -> Operando_A=5, Operando_B=7, Control=00, rd_out=3, we_out=1.
- SRAI x4,x1,0x23 (imm=0x00000423, b5=1) -> Control=01, Operando_B=0x00000003. R-type SRA with rs2_data=0xFFFFFFE5 -> Operando_B=0x00000005.
- Forwarding: rs1=x6 with exmem (we=1, rd=6, res=0xAA) and memwb (we=1, rd=6, res=0xBB) -> Operando_A=0xAA. With exmem_we=0 -> 0xBB. With rs1=x0 and both matching rd=0 -> Operando_A=0.
- Stall: out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and outputs unchanged. out_ready=1 -> next instruction captured the following edge. flush=1 during the stall -> out_valid=0 next edge.
- Illegal (opcode 0110011, funct3 010) -> illegal=1, we_out=0, Control=00, out_valid=1. ADDI with rd=x0 -> we_out=0, illegal=0.
